// File: rtl/seq_pattern_det_if.sv
// rtl/seq_pattern_det_if.sv - serial input, pattern config and hit status bundle for seq_pattern_det
interface seq_pattern_det_if #(
    parameter int NPAT  = 4,
    parameter int PLEN  = 4,
    parameter int CNT_W = 8
);
    localparam int SW = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int LW = $clog2(PLEN + 1);

    logic                    clear;
    logic                    in;
    logic                    in_valid;
    logic                    overlap;
    logic                    cfg_we;
    logic [SW-1:0]           cfg_sel;
    logic [PLEN-1:0]         cfg_pat;
    logic [LW-1:0]           cfg_len;
    logic [NPAT-1:0]         hit;
    logic                    any_hit;
    logic [NPAT*CNT_W-1:0]   hit_cnt;

    modport master (
        output clear, in, in_valid, overlap, cfg_we, cfg_sel, cfg_pat, cfg_len,
        input  hit, any_hit, hit_cnt
    );

    modport slave (
        input  clear, in, in_valid, overlap, cfg_we, cfg_sel, cfg_pat, cfg_len,
        output hit, any_hit, hit_cnt
    );
endinterface

// File: rtl/seq_pattern_det.sv
// rtl/seq_pattern_det.sv - multi-channel programmable serial pattern detector with saturating hit counters
module seq_pattern_det #(
    parameter int NPAT  = 4,
    parameter int PLEN  = 4,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rest,
    seq_pattern_det_if.slave bus
);
    localparam int SW = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int LW = $clog2(PLEN + 1);

    typedef logic [LW-1:0] len_t;

    // Only PLEN-1 past bits are stored: the newest bit arrives on 'in' and
    // completes the PLEN-bit window combinationally.
    logic [PLEN-2:0]   hist;
    len_t              fill;
    len_t              spc  [NPAT];
    logic [PLEN-1:0]   pat  [NPAT];
    len_t              len  [NPAT];
    logic [CNT_W-1:0]  cnt  [NPAT];
    logic [NPAT-1:0]   hit_q;
    logic              any_q;

    logic [PLEN-1:0]   nhist;
    logic [NPAT-1:0]   match;
    logic [NPAT-1:0]   sel;
    logic              eq;

    function automatic logic [PLEN-1:0] def_pat(input int i);
        logic [31:0] p;
        case (i)
            0:       p = 32'he;
            1:       p = 32'h6;
            2:       p = 32'hc;
            3:       p = 32'h9;
            default: p = 32'h0;
        endcase
        return p[PLEN-1:0];
    endfunction

    function automatic len_t def_len(input int i);
        int base;
        case (i)
            0:       base = 4;
            1:       base = 3;
            2:       base = 4;
            3:       base = 4;
            default: base = 0;
        endcase
        return (base > PLEN) ? LW'(PLEN) : LW'(base);
    endfunction

    // Window evaluation: which channels match if the current bit is taken
    always_comb begin
        nhist = {hist, bus.in};
        match = '0;
        sel   = '0;
        eq    = 1'b1;
        for (int i = 0; i < NPAT; i++) begin
            sel[i] = bus.cfg_we && (bus.cfg_sel == SW'(i));
            eq = 1'b1;
            for (int b = 0; b < PLEN; b++) begin
                if ((b < int'(len[i])) && (nhist[b] != pat[i][b])) begin
                    eq = 1'b0;
                end
            end
            if (bus.in_valid && (len[i] != '0) && (int'(fill) + 1 >= int'(len[i])) && eq
                && (bus.overlap || (int'(spc[i]) + 1 >= int'(len[i])))) begin
                match[i] = 1'b1;
            end
        end
    end

    // History, spacing, counters, flags and channel config registers
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            hist  <= '0;
            fill  <= '0;
            hit_q <= '0;
            any_q <= 1'b0;
            for (int i = 0; i < NPAT; i++) begin
                spc[i] <= LW'(PLEN);
                cnt[i] <= '0;
                pat[i] <= def_pat(i);
                len[i] <= def_len(i);
            end
        end else begin
            if (bus.clear) begin
                hist  <= '0;
                fill  <= '0;
                hit_q <= '0;
                any_q <= 1'b0;
                for (int i = 0; i < NPAT; i++) begin
                    spc[i] <= LW'(PLEN);
                    cnt[i] <= '0;
                end
            end else begin
                hit_q <= match;
                any_q <= |match;
                if (bus.in_valid) begin
                    hist <= nhist[PLEN-2:0];
                    if (fill != LW'(PLEN)) begin
                        fill <= fill + LW'(1);
                    end
                end
                for (int i = 0; i < NPAT; i++) begin
                    if (sel[i]) begin
                        spc[i] <= LW'(PLEN);
                        cnt[i] <= '0;
                    end else begin
                        if (bus.in_valid) begin
                            if (match[i]) begin
                                spc[i] <= '0;
                            end else if (spc[i] != LW'(PLEN)) begin
                                spc[i] <= spc[i] + LW'(1);
                            end
                        end
                        if (match[i] && (cnt[i] != '1)) begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
            // Config survives clear; a write lands regardless of clear
            for (int i = 0; i < NPAT; i++) begin
                if (sel[i]) begin
                    pat[i] <= bus.cfg_pat;
                    len[i] <= (bus.cfg_len > LW'(PLEN)) ? LW'(PLEN) : bus.cfg_len;
                end
            end
        end
    end

    // Status outputs straight from registers
    always_comb begin
        bus.hit     = hit_q;
        bus.any_hit = any_q;
        bus.hit_cnt = '0;
        for (int i = 0; i < NPAT; i++) begin
            bus.hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
endmodule

// File: tb/tb_seq_pattern_det.sv
// tb/tb_seq_pattern_det.sv - scoreboard bench for seq_pattern_det with a queue-based reference model
module tb_seq_pattern_det;
    localparam int NPAT  = 4;
    localparam int PLEN  = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [NPAT-1:0]       hit;
        logic                  any;
        logic [NPAT*CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rest;
    always #5 clk = ~clk;

    seq_pattern_det_if #(.NPAT(NPAT), .PLEN(PLEN), .CNT_W(CNT_W)) bus ();
    seq_pattern_det #(.NPAT(NPAT), .PLEN(PLEN), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int   m_hist[$];
    int   m_spc [NPAT];
    int   m_cnt [NPAT];
    int   m_pat [NPAT];
    int   m_len [NPAT];
    bit   g_ov = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < NPAT; i++) begin
            m_spc[i] = PLEN;
            m_cnt[i] = 0;
        end
        m_pat[0] = 'he; m_len[0] = 4;
        m_pat[1] = 'h6; m_len[1] = 3;
        m_pat[2] = 'hc; m_len[2] = 4;
        m_pat[3] = 'h9; m_len[3] = 4;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;
        bus.clear    = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = '0;
        bus.cfg_pat  = '0;
        bus.cfg_len  = '0;
        bus.overlap  = g_ov;
    endtask

    // One cycle of stimulus; the model predicts the registered outputs after the next edge
    task automatic drive(input bit iv, input bit b, input bit clr, input bit we,
                         input int sel, input int pat, input int len);
        exp_t e;
        int   nh[$];
        bit   m;
        @(negedge clk);
        bus.in_valid = iv;
        bus.in       = b;
        bus.clear    = clr;
        bus.overlap  = g_ov;
        bus.cfg_we   = we;
        bus.cfg_sel  = 2'(sel);
        bus.cfg_pat  = 4'(pat);
        bus.cfg_len  = 3'(len);
        e.hit = '0;
        if (clr) begin
            m_hist.delete();
            for (int i = 0; i < NPAT; i++) begin
                m_spc[i] = PLEN;
                m_cnt[i] = 0;
            end
        end else begin
            if (iv) begin
                nh = m_hist;
                nh.push_front(int'(b));
                if (nh.size() > PLEN) void'(nh.pop_back());
                for (int i = 0; i < NPAT; i++) begin
                    m = (m_len[i] > 0) && (nh.size() >= m_len[i]) && (g_ov || (m_spc[i] + 1 >= m_len[i]));
                    for (int k = 0; k < m_len[i]; k++) begin
                        if (k < nh.size() && nh[k] != ((m_pat[i] >> k) & 1)) m = 1'b0;
                    end
                    e.hit[i] = m;
                    m_spc[i] = m ? 0 : ((m_spc[i] < PLEN) ? m_spc[i] + 1 : PLEN);
                    if (m && m_cnt[i] < CMAX) m_cnt[i]++;
                end
                m_hist = nh;
            end
            if (we && sel < NPAT) begin
                m_cnt[sel] = 0;
                m_spc[sel] = PLEN;
            end
        end
        if (we && sel < NPAT) begin
            m_pat[sel] = pat & ((1 << PLEN) - 1);
            m_len[sel] = (len > PLEN) ? PLEN : len;
        end
        e.any = |e.hit;
        for (int i = 0; i < NPAT; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit b);
        drive(1'b1, b, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg(input int sel, input int pat, input int len);
        drive(1'b0, 1'b0, 1'b0, 1'b1, sel, pat, len);
    endtask

    // Directed spot check against fixed values right after the edge following the last drive
    task automatic chk_now(input string nm, input logic [NPAT-1:0] h, input logic [NPAT*CNT_W-1:0] c);
        @(posedge clk);
        #2;
        chk({nm, "_hit"}, 64'(bus.hit), 64'(h));
        chk({nm, "_cnt"}, 64'(bus.hit_cnt), 64'(c));
    endtask

    // Asynchronous reset between edges, checked before any further clock edge
    task automatic do_reset(input string nm);
        @(posedge clk);
        #3;
        set_idle();
        rest = 1'b1;
        #1;
        chk({nm, "_rst_hit"}, 64'(bus.hit), 64'd0);
        chk({nm, "_rst_any"}, 64'(bus.any_hit), 64'd0);
        chk({nm, "_rst_cnt"}, 64'(bus.hit_cnt), 64'd0);
        @(negedge clk);
        rest = 1'b0;
        model_reset();
    endtask

    // Monitor: every edge that follows a drive has a prediction waiting
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hit", 64'(bus.hit), 64'(e.hit));
                chk("any_hit", 64'(bus.any_hit), 64'(e.any));
                chk("hit_cnt", 64'(bus.hit_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        int r;
        set_idle();
        rest = 1'b1;
        model_reset();
        #2;
        chk("por_hit", 64'(bus.hit), 64'd0);
        chk("por_any", 64'(bus.any_hit), 64'd0);
        chk("por_cnt", 64'(bus.hit_cnt), 64'd0);
        @(negedge clk);
        rest = 1'b0;

        // default channels on 1,1,1,0
        bit_in(1); bit_in(1); bit_in(1); bit_in(0);
        chk_now("t1", 4'b0011, 8'h05);
        chk("t1_any", 64'(bus.any_hit), 64'd1);

        // ch0 = 11/len2 overlapping, then non-overlapping after a clear
        g_ov = 1'b1;
        cfg(0, 3, 2);
        bit_in(1); bit_in(1); bit_in(1); bit_in(1);
        chk_now("t2_ovl", 4'b0001, 8'h07);
        g_ov = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        bit_in(1); bit_in(1); bit_in(1); bit_in(1);
        chk_now("t2_novl", 4'b0001, 8'h02);
        g_ov = 1'b1;

        // fill guard with gaps between bits
        do_reset("t3");
        cfg(1, 0, 3);
        bit_in(0); gap(); bit_in(0); gap(); gap(); bit_in(0);
        chk_now("t3_hit", 4'b0010, 8'h04);
        gap();
        chk_now("t3_after", 4'b0000, 8'h04);

        // counter saturation and cfg write colliding with a match
        cfg(0, 3, 2);
        for (int k = 0; k < 5; k++) bit_in(1);
        chk_now("t4_sat", 4'b0001, 8'h07);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 3, 2);
        chk_now("t4_cfgwr", 4'b0001, 8'h04);

        // clear together with the completing bit
        do_reset("t5");
        bit_in(1); bit_in(1); bit_in(1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk_now("t5_clr", 4'b0000, 8'h00);
        bit_in(1); bit_in(1); bit_in(1); bit_in(0);
        chk_now("t5_after", 4'b0011, 8'h05);

        // async reset while hits and counts are live, then fill guard again
        do_reset("t6a");
        bit_in(1); bit_in(1); bit_in(1); bit_in(0);
        do_reset("t6b");
        bit_in(0);
        chk_now("t6_post", 4'b0000, 8'h00);

        // randomized traffic with occasional clears, config writes and mode toggles
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) g_ov = ~g_ov;
            if (r >= 3 && r < 5) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            end else if (r >= 5 && r < 9) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            end else begin
                drive(r < 80, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0, 0);
            end
        end
        gap();
        @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
